// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main control unit: Moore FSM that sequences fetch, decode,
// execute, memory and writeback, plus the ALU control decoder.
module mips_mc_controller #(
    parameter bit EN_BNE = 1'b1,
    parameter bit EN_ORI = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       lord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       immzext,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        IMMWB  = 4'd10,
        JUMP   = 4'd11,
        ORIEX  = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        ALU_NONE  = 3'd0,
        ALU_ADD   = 3'd1,
        ALU_SUB   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_FUNCT = 3'd4
    } aluop_t;

    state_t state;
    state_t state_next;
    state_t state_dec;
    aluop_t aluop;
    logic   pcwrite;
    logic   branch;

    assign state_o = state;

    // State register; reset abandons any partial instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore output decode; reset decodes as FETCH with enables gated off
    always_comb begin
        state_next = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        lord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        immzext    = 1'b0;
        pcsrc      = 2'b00;
        aluop      = ALU_NONE;
        illegal    = 1'b0;
        pcen       = 1'b0;
        state_dec  = reset ? FETCH : state;

        case (state_dec)
            FETCH: begin
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
                alusrcb    = 2'b01;
                aluop      = ALU_ADD;
                state_next = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                aluop   = ALU_ADD;
                if (op == OP_LW || op == OP_SW) begin
                    state_next = MEMADR;
                end else if (op == OP_RTYPE) begin
                    state_next = EXEC;
                end else if (op == OP_BEQ || (EN_BNE && op == OP_BNE)) begin
                    state_next = BRANCH;
                end else if (op == OP_ADDI) begin
                    state_next = ADDIEX;
                end else if (EN_ORI && op == OP_ORI) begin
                    state_next = ORIEX;
                end else if (op == OP_J) begin
                    state_next = JUMP;
                end else begin
                    state_next = FETCH;
                    illegal    = 1'b1;
                end
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                aluop      = ALU_ADD;
                state_next = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                lord       = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                lord     = 1'b1;
                memwrite = 1'b1;
            end
            EXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b00;
                aluop      = ALU_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                aluop   = ALU_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                aluop      = ALU_ADD;
                state_next = IMMWB;
            end
            ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                immzext    = 1'b1;
                aluop      = ALU_OR;
                state_next = IMMWB;
            end
            IMMWB: begin
                regwrite = 1'b1;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        pcen = pcwrite
             | (branch && op == OP_BEQ && zero)
             | (branch && EN_BNE && op == OP_BNE && !zero);

        if (reset) begin
            pcen     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    // ALU control decode from the abstract ALU operation and funct field
    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            ALU_ADD: alucontrol = 3'b010;
            ALU_SUB: alucontrol = 3'b110;
            ALU_OR:  alucontrol = 3'b001;
            ALU_FUNCT: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized self-checking bench for mips_mc_controller against an
// instruction-level reference model (state path + per-step control meaning).
module tb_mips_mc_controller;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] JMP  = 6'b000010;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, lord, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, immzext, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_o;
    logic [16:0] outs;

    int errors = 0;
    int checks = 0;

    mips_mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .lord(lord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .immzext(immzext),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign outs = {pcen, lord, memwrite, irwrite, regdst, memtoreg, regwrite,
                   alusrca, alusrcb, immzext, pcsrc, alucontrol, illegal};

    // Compare one observed value with its expectation
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (op=%b funct=%b zero=%b)",
                     tag, obs, exp, op, funct, zero);
        end
    endtask

    function automatic bit supported(input logic [5:0] o);
        return o inside {LW, SW, RT, BEQ, BNE, ADDI, ORI, JMP};
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Step sequence (state codes) an instruction walks through
    task automatic instr_path(input logic [5:0] o, output int n, output int p[6]);
        p = '{0, 0, 0, 0, 0, 0};
        case (o)
            LW:       begin n = 5; p = '{0, 1, 2, 3, 4, 0}; end
            SW:       begin n = 4; p = '{0, 1, 2, 5, 0, 0}; end
            RT:       begin n = 4; p = '{0, 1, 6, 7, 0, 0}; end
            ADDI:     begin n = 4; p = '{0, 1, 9, 10, 0, 0}; end
            ORI:      begin n = 4; p = '{0, 1, 12, 10, 0, 0}; end
            BEQ, BNE: begin n = 3; p = '{0, 1, 8, 0, 0, 0}; end
            JMP:      begin n = 3; p = '{0, 1, 11, 0, 0, 0}; end
            default:  begin n = 2; p = '{0, 1, 0, 0, 0, 0}; end
        endcase
    endtask

    // Expected control outputs for one step of an instruction
    function automatic logic [16:0] exp_out(input int s, input logic [5:0] o,
                                            input logic [5:0] f, input logic z,
                                            input logic rst);
        logic pc_e, lo_e, mw_e, ir_e, rd_e, m2r_e, rw_e, sa_e, iz_e, il_e;
        logic [1:0] sb_e, ps_e;
        logic [2:0] alu_e;
        int st;
        {pc_e, lo_e, mw_e, ir_e, rd_e, m2r_e, rw_e, sa_e, iz_e, il_e} = '0;
        sb_e = 2'b00; ps_e = 2'b00; alu_e = 3'b000;
        st = rst ? 0 : s;
        case (st)
            0:  begin ir_e = 1; pc_e = 1; sb_e = 2'b01; alu_e = 3'b010; end
            1:  begin sb_e = 2'b11; alu_e = 3'b010; il_e = !supported(o); end
            2:  begin sa_e = 1; sb_e = 2'b10; alu_e = 3'b010; end
            3:  lo_e = 1;
            4:  begin m2r_e = 1; rw_e = 1; end
            5:  begin lo_e = 1; mw_e = 1; end
            6:  begin sa_e = 1; alu_e = funct_alu(f); end
            7:  begin rd_e = 1; rw_e = 1; end
            8:  begin
                    sa_e = 1; alu_e = 3'b110; ps_e = 2'b01;
                    pc_e = (o == BEQ && z) || (o == BNE && !z);
                end
            9:  begin sa_e = 1; sb_e = 2'b10; alu_e = 3'b010; end
            10: rw_e = 1;
            11: begin ps_e = 2'b10; pc_e = 1; end
            12: begin sa_e = 1; sb_e = 2'b10; iz_e = 1; alu_e = 3'b001; end
            default: ;
        endcase
        if (rst) begin
            pc_e = 0; mw_e = 0; ir_e = 0; rw_e = 0; il_e = 0;
        end
        return {pc_e, lo_e, mw_e, ir_e, rd_e, m2r_e, rw_e, sa_e, sb_e, iz_e, ps_e, alu_e, il_e};
    endfunction

    // Run one instruction from FETCH; zmode<0 randomizes zero, rst_at asserts reset in that step
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int zmode, input int rst_at);
        int n;
        int p[6];
        instr_path(o, n, p);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                op = o;
                funct = f;
            end
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
            if (p[i] == rst_at) reset = 1'b1;
            #1;
            check("state", 32'(state_o), 32'(p[i]));
            check("outputs", 32'(outs), 32'(exp_out(p[i], o, f, zero, reset)));
            if (reset) begin
                @(posedge clk);
                #1;
                check("state_after_reset", 32'(state_o), 32'd0);
                reset = 1'b0;
                return;
            end
            @(posedge clk);
        end
    endtask

    logic [5:0] ops [8] = '{LW, SW, RT, BEQ, BNE, ADDI, ORI, JMP};
    logic [5:0] functs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    initial begin
        logic [5:0] o;
        logic [5:0] f;
        int k;
        reset = 1'b1;
        op    = LW;
        funct = 6'b000000;
        zero  = 1'b0;

        // Reset held for three edges
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_state", 32'(state_o), 32'd0);
            check("reset_enables", 32'({pcen, irwrite, memwrite, regwrite, illegal}), 32'd0);
        end
        reset = 1'b0;

        // Directed instructions
        run_instr(LW,   6'b000000, -1, -1);
        run_instr(SW,   6'b010100, -1, -1);
        run_instr(BEQ,  6'b000000,  1, -1);
        run_instr(BEQ,  6'b000000,  0, -1);
        run_instr(BNE,  6'b000000,  0, -1);
        run_instr(BNE,  6'b000000,  1, -1);
        for (int i = 0; i < 6; i++) run_instr(RT, functs[i], -1, -1);
        run_instr(ADDI, 6'b000000, -1, -1);
        run_instr(ORI,  6'b000000, -1, -1);
        run_instr(JMP,  6'b000000, -1, -1);
        run_instr(6'b111111, 6'b000000, -1, -1);
        run_instr(SW,   6'b000000, -1, 5);
        run_instr(LW,   6'b000000, -1, -1);

        // Random instruction stream with occasional mid-instruction reset
        for (int t = 0; t < 200; t++) begin
            k = int'($urandom_range(0, 9));
            if (k < 8) begin
                o = ops[k];
            end else begin
                o = 6'($urandom);
                while (supported(o)) o = 6'($urandom);
            end
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
            if ($urandom_range(0, 15) == 0)
                run_instr(o, f, -1, int'($urandom_range(0, 12)));
            else
                run_instr(o, f, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
